// File: rtl/cache_line_fill.sv
// Miss-refill engine: fetches one 8-beat line critical-word-first with wrap,
// forwards the critical word, then writes data plus {tag, valid} into the victim way.
module cache_line_fill #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned TAG_W      = 18,
    parameter int unsigned INDEX_W    = 7,
    parameter int unsigned LINE_BEATS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         iMissValid,
    output logic                         oMissReady,
    input  logic [ADDR_W-1:0]            iMissAddr,
    input  logic [1:0]                   iVictimWay,
    output logic                         oMemReq,
    input  logic                         iMemGnt,
    output logic [ADDR_W-1:0]            oMemAddr,
    input  logic                         iMemDataValid,
    input  logic [DATA_W-1:0]            iMemData,
    input  logic                         iMemErr,
    output logic                         oCritValid,
    output logic [DATA_W-1:0]            oCritData,
    output logic                         oLineWr,
    output logic [1:0]                   oLineWay,
    output logic [INDEX_W-1:0]           oLineIndex,
    output logic [TAG_W:0]               oLineTag,
    output logic [LINE_BEATS*DATA_W-1:0] oLineData,
    output logic                         oFillDone,
    output logic                         oFillErr
);

    localparam int unsigned CNT_W  = $clog2(LINE_BEATS);
    localparam int unsigned IDX_LO = CNT_W + 2;
    localparam int unsigned TAG_LO = IDX_LO + INDEX_W;

    typedef enum logic [1:0] {IDLE, REQ, DATA, WRITE} state_t;

    state_t                   state, nextState;
    logic [ADDR_W-1:2]        missAddr;
    logic [1:0]               way;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         crit;
    logic [CNT_W-1:0]         slot;
    logic [DATA_W-1:0]        lineBuf [LINE_BEATS];
    logic [LINE_BEATS*DATA_W-1:0] lineFlat;
    logic                     critQ;
    logic                     errQ;
    logic                     holdOff;
    logic [DATA_W-1:0]        critData;
    logic                     beat;
    logic                     accept;
    logic                     unusedResv;

    assign unusedResv = ^iMissAddr[1:0];

    assign crit   = missAddr[IDX_LO-1:2];
    assign slot   = crit + cnt;
    assign beat   = (state == DATA) && iMemDataValid;
    // holdOff keeps ready low during reset and for the cycle carrying oFillErr
    assign oMissReady = (state == IDLE) && !holdOff;
    assign accept = iMissValid && oMissReady;

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (accept) nextState = REQ;
            REQ:   if (iMemGnt) nextState = DATA;
            DATA: begin
                if (beat) begin
                    if (iMemErr)    nextState = IDLE;
                    else if (&cnt)  nextState = WRITE;
                end
            end
            WRITE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            missAddr <= '0;
            way      <= '0;
            cnt      <= '0;
            critQ    <= 1'b0;
            errQ     <= 1'b0;
            holdOff  <= 1'b1;
            critData <= '0;
        end else begin
            state   <= nextState;
            critQ   <= beat && !iMemErr && (cnt == '0);
            errQ    <= beat && iMemErr;
            holdOff <= beat && iMemErr;
            if (accept) begin
                missAddr <= iMissAddr[ADDR_W-1:2];
                way      <= iVictimWay;
                cnt      <= '0;
            end
            if (beat && !iMemErr) begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) critData <= iMemData;
            end
        end
    end

    // Line buffer is deliberately not reset; every slot is rewritten by a good fill.
    always_ff @(posedge clk) begin
        if (beat && !iMemErr) lineBuf[slot] <= iMemData;
    end

    always_comb begin
        lineFlat = '0;
        for (int unsigned w = 0; w < LINE_BEATS; w++)
            lineFlat[w*DATA_W +: DATA_W] = lineBuf[w];
    end

    assign oMemReq    = (state == REQ);
    assign oMemAddr   = oMemReq ? {missAddr, 2'b00} : '0;
    assign oCritValid = critQ;
    assign oCritData  = critData;
    assign oFillErr   = errQ;
    assign oLineWr    = (state == WRITE);
    assign oFillDone  = oLineWr;
    assign oLineWay   = oLineWr ? way : '0;
    assign oLineIndex = oLineWr ? missAddr[IDX_LO +: INDEX_W] : '0;
    assign oLineTag   = oLineWr ? {missAddr[TAG_LO +: TAG_W], 1'b1} : '0;
    assign oLineData  = oLineWr ? lineFlat : '0;

endmodule

// File: tb/tb_cache_line_fill.sv
// Bench for cache_line_fill: vector table, hand-written reset/spurious sequences,
// and randomized fills against a cycle-arithmetic reference model.
module tb_cache_line_fill;

    logic         clk;
    logic         reset;
    logic         iMissValid;
    logic         oMissReady;
    logic [31:0]  iMissAddr;
    logic [1:0]   iVictimWay;
    logic         oMemReq;
    logic         iMemGnt;
    logic [31:0]  oMemAddr;
    logic         iMemDataValid;
    logic [31:0]  iMemData;
    logic         iMemErr;
    logic         oCritValid;
    logic [31:0]  oCritData;
    logic         oLineWr;
    logic [1:0]   oLineWay;
    logic [6:0]   oLineIndex;
    logic [18:0]  oLineTag;
    logic [255:0] oLineData;
    logic         oFillDone;
    logic         oFillErr;

    cache_line_fill #(
        .ADDR_W(32), .DATA_W(32), .TAG_W(18), .INDEX_W(7), .LINE_BEATS(8)
    ) dut (
        .clk(clk), .reset(reset),
        .iMissValid(iMissValid), .oMissReady(oMissReady),
        .iMissAddr(iMissAddr), .iVictimWay(iVictimWay),
        .oMemReq(oMemReq), .iMemGnt(iMemGnt), .oMemAddr(oMemAddr),
        .iMemDataValid(iMemDataValid), .iMemData(iMemData), .iMemErr(iMemErr),
        .oCritValid(oCritValid), .oCritData(oCritData),
        .oLineWr(oLineWr), .oLineWay(oLineWay), .oLineIndex(oLineIndex),
        .oLineTag(oLineTag), .oLineData(oLineData),
        .oFillDone(oFillDone), .oFillErr(oFillErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int strobeSeen = 0;

    always @(posedge clk) if (oLineWr || oFillDone || oFillErr) strobeSeen++;

    task automatic check(input string name, input logic [399:0] act, input logic [399:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [399:0] outVec();
        return 400'({oMissReady, oMemReq, oMemAddr, oCritValid, oCritData, oLineWr,
                     oLineWay, oLineIndex, oLineTag, oLineData, oFillDone, oFillErr});
    endfunction

    task automatic driveIdle();
        iMissValid = 1'b0; iMissAddr = '0; iVictimWay = '0; iMemGnt = 1'b0;
        iMemDataValid = 1'b0; iMemData = '0; iMemErr = 1'b0;
    endtask

    // Cycle 0 is the acceptance cycle; everything else is derived from grant delay and beat gap.
    task automatic runFill(input string tag, input logic [31:0] addr, input logic [1:0] way,
                           input int gd, input int gap, input int errBeat,
                           input logic [31:0] beats [8], input bit stray,
                           input logic [31:0] expMemAddr, input logic [6:0] expIndex,
                           input logic [17:0] expTag);
        int crit, grantCyc, first, nBeats, lastCyc, endCyc;
        int reqBad, addrBad, readyBad, doneBad, critN, critCyc, wrN, wrCyc, errN, errCyc;
        logic [31:0]  critVal;
        logic [255:0] gotLine, expLine;
        logic [18:0]  gotTag;
        logic [6:0]   gotIdx;
        logic [1:0]   gotWay;
        bit expReq, expReady;
        crit     = int'(addr / 4) % 8;
        grantCyc = 1 + gd;
        first    = grantCyc + 1;
        nBeats   = (errBeat >= 0) ? errBeat + 1 : 8;
        lastCyc  = first + (nBeats - 1) * (gap + 1);
        endCyc   = lastCyc + 2;
        reqBad = 0; addrBad = 0; readyBad = 0; doneBad = 0;
        critN = 0; critCyc = -1; wrN = 0; wrCyc = -1; errN = 0; errCyc = -1;
        critVal = '0; gotLine = '0; gotTag = '0; gotIdx = '0; gotWay = '0;
        for (int c = 0; c <= endCyc; c++) begin
            @(negedge clk);
            expReq   = (c >= 1) && (c <= grantCyc);
            expReady = (c == 0) || (c == endCyc);
            if (oMemReq !== expReq) reqBad++;
            if (expReq && oMemAddr !== expMemAddr) addrBad++;
            if (oMissReady !== expReady) readyBad++;
            if (oFillDone !== oLineWr) doneBad++;
            if (oCritValid) begin critN++; critCyc = c; critVal = oCritData; end
            if (oLineWr) begin
                wrN++; wrCyc = c; gotLine = oLineData; gotTag = oLineTag;
                gotIdx = oLineIndex; gotWay = oLineWay;
            end
            if (oFillErr) begin errN++; errCyc = c; end
            iMissValid = 1'b0; iMissAddr = $urandom; iVictimWay = 2'($urandom);
            iMemGnt = 1'b0; iMemDataValid = 1'b0; iMemData = $urandom; iMemErr = 1'b0;
            if (c == 0) begin
                iMissValid = 1'b1; iMissAddr = addr; iVictimWay = way;
            end else if (stray && c < endCyc) begin
                iMissValid = 1'b1;
            end
            if (c >= 1 && c <= grantCyc) begin
                iMemDataValid = 1'b1; iMemErr = 1'($urandom);
            end
            if (c == grantCyc) iMemGnt = 1'b1;
            if (c > first) iMemGnt = 1'($urandom);
            if (c == lastCyc + 1) iMemDataValid = 1'b1;
            for (int i = 0; i < nBeats; i++) begin
                if (c == first + i * (gap + 1)) begin
                    iMemDataValid = 1'b1; iMemData = beats[i]; iMemErr = (i == errBeat);
                end
            end
            if (c == endCyc) driveIdle();
        end
        for (int w = 0; w < 8; w++) expLine[w*32 +: 32] = beats[(w - crit + 8) % 8];
        check({tag, ".memReq"},    400'(reqBad),   400'(0));
        check({tag, ".memAddr"},   400'(addrBad),  400'(0));
        check({tag, ".missReady"}, 400'(readyBad), 400'(0));
        check({tag, ".fillDone"},  400'(doneBad),  400'(0));
        if (errBeat < 0) begin
            check({tag, ".critN"},    400'(critN),   400'(1));
            check({tag, ".critCyc"},  400'(critCyc), 400'(first + 1));
            check({tag, ".critData"}, 400'(critVal), 400'(beats[0]));
            check({tag, ".wrN"},      400'(wrN),     400'(1));
            check({tag, ".wrCyc"},    400'(wrCyc),   400'(lastCyc + 1));
            check({tag, ".errN"},     400'(errN),    400'(0));
            check({tag, ".line"},     400'(gotLine), 400'(expLine));
            check({tag, ".tag"},      400'(gotTag),  400'({expTag, 1'b1}));
            check({tag, ".index"},    400'(gotIdx),  400'(expIndex));
            check({tag, ".way"},      400'(gotWay),  400'(way));
        end else begin
            check({tag, ".wrN"},    400'(wrN),    400'(0));
            check({tag, ".errN"},   400'(errN),   400'(1));
            check({tag, ".errCyc"}, 400'(errCyc), 400'(lastCyc + 1));
            check({tag, ".critN"},  400'(critN),  400'(errBeat > 0 ? 1 : 0));
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [1:0]  way;
        int          gd;
        int          gap;
        int          errBeat;
        logic [31:0] base;
        bit          stray;
        logic [31:0] expMemAddr;
        logic [6:0]  expIndex;
        logic [17:0] expTag;
    } vec_t;

    vec_t        vecs [5];
    logic [31:0] beats [8];

    initial begin
        vecs[0] = '{"aligned", 32'h0000_1A40, 2'd2, 0, 0, -1, 32'hA0, 1'b0, 32'h0000_1A40, 7'h52, 18'h00001};
        vecs[1] = '{"wrap",    32'h0000_1A54, 2'd1, 0, 0, -1, 32'hB0, 1'b0, 32'h0000_1A54, 7'h52, 18'h00001};
        vecs[2] = '{"stall",   32'h8765_4328, 2'd3, 4, 1, -1, 32'hC0, 1'b1, 32'h8765_4328, 7'h19, 18'h07654};
        vecs[3] = '{"error",   32'h0000_2A6C, 2'd0, 0, 0,  3, 32'hD0, 1'b1, 32'h0000_2A6C, 7'h53, 18'h00002};
        vecs[4] = '{"resv",    32'hC000_0FFF, 2'd0, 1, 0, -1, 32'hE0, 1'b0, 32'hC000_0FFC, 7'h7F, 18'h00000};

        driveIdle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("resetOutputs", outVec(), '0);
        reset = 1'b0;
        @(negedge clk);
        check("readyAfterReset", 400'(oMissReady), 400'(1));

        // Stray grant/data in IDLE must not advance the beat counter.
        iMemGnt = 1'b1; iMemDataValid = 1'b1; iMemData = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check("idleSpurious", 400'({oMissReady, oMemReq, oCritValid, oLineWr}), 400'(4'b1000));
        driveIdle();

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < 8; i++) beats[i] = vecs[v].base + 32'(i);
            runFill(vecs[v].name, vecs[v].addr, vecs[v].way, vecs[v].gd, vecs[v].gap,
                    vecs[v].errBeat, beats, vecs[v].stray, vecs[v].expMemAddr,
                    vecs[v].expIndex, vecs[v].expTag);
        end

        // Reset after four accepted beats: everything clears and no strobe escapes.
        strobeSeen = 0;
        @(negedge clk);
        iMissValid = 1'b1; iMissAddr = 32'h0000_1A40; iVictimWay = 2'd1;
        @(negedge clk);
        iMissValid = 1'b0; iMemGnt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            iMemGnt = 1'b0; iMemDataValid = 1'b1; iMemData = 32'h55 + 32'(i);
        end
        @(negedge clk);
        driveIdle();
        reset = 1'b1;
        @(negedge clk);
        check("midResetOutputs", outVec(), '0);
        @(negedge clk);
        check("midResetHeld", outVec(), '0);
        reset = 1'b0;
        @(negedge clk);
        check("midResetReady", 400'(oMissReady), 400'(1));
        check("midResetNoStrobe", 400'(strobeSeen), 400'(0));
        for (int i = 0; i < 8; i++) beats[i] = 32'h7700 + 32'(i);
        runFill("afterReset", 32'h0000_1A4C, 2'd1, 0, 0, -1, beats, 1'b0,
                32'h0000_1A4C, 7'h52, 18'h00001);

        for (int n = 0; n < 25; n++) begin
            logic [31:0] a;
            int eb;
            a  = $urandom;
            eb = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : -1;
            for (int i = 0; i < 8; i++) beats[i] = $urandom;
            runFill($sformatf("rand%0d", n), a, 2'($urandom), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 2)), eb, beats, 1'($urandom),
                    a - (a % 4), 7'((a / 32) % 128), 18'((a / 4096) % 262144));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
